// File: rtl/bp_fe_btb_writer.sv
// Queues BTB updates and replays them onto the BTB write port after the post-reset table sweep.
// Define BP_FE_BTB_WRITER_COALESCE_EN to merge an update into the newest queued entry with the same index.
module bp_fe_btb_writer #(
  parameter vaddr_width_p   = "inv",
  parameter btb_tag_width_p = "inv",
  parameter btb_idx_width_p = "inv",
  parameter fifo_els_p      = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       upd_v_i,
  output logic                       upd_ready_o,
  input  logic                       upd_clr_i,
  input  logic                       upd_jmp_i,
  input  logic [vaddr_width_p-1:0]   upd_pc_i,
  input  logic [vaddr_width_p-1:0]   upd_tgt_i,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic                       w_clr_o,
  output logic                       w_jmp_o,
  output logic [btb_tag_width_p-1:0] w_tag_o,
  output logic [btb_idx_width_p-1:0] w_idx_o,
  output logic [vaddr_width_p-1:0]   br_tgt_o
);

  localparam int ptr_w  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w  = $clog2(fifo_els_p + 1);
  localparam int wait_w = btb_idx_width_p + 1;
  localparam logic [wait_w-1:0] wait_last = {1'b1, {btb_idx_width_p{1'b0}}};

  typedef enum logic [1:0] {e_reset, e_wait, e_run} state_e;

  state_e                     state_q, state_d;
  logic [wait_w-1:0]          wait_cnt_q, wait_cnt_d;
  logic [ptr_w-1:0]           rd_ptr_q, rd_ptr_d;
  logic [ptr_w-1:0]           wr_ptr_q, wr_ptr_d;
  logic [cnt_w-1:0]           count_q, count_d;

  logic                       mem_clr_q [fifo_els_p];
  logic                       mem_clr_d [fifo_els_p];
  logic                       mem_jmp_q [fifo_els_p];
  logic                       mem_jmp_d [fifo_els_p];
  logic [btb_tag_width_p-1:0] mem_tag_q [fifo_els_p];
  logic [btb_tag_width_p-1:0] mem_tag_d [fifo_els_p];
  logic [btb_idx_width_p-1:0] mem_idx_q [fifo_els_p];
  logic [btb_idx_width_p-1:0] mem_idx_d [fifo_els_p];
  logic [vaddr_width_p-1:0]   mem_tgt_q [fifo_els_p];
  logic [vaddr_width_p-1:0]   mem_tgt_d [fifo_els_p];

  logic [btb_idx_width_p-1:0] upd_idx;
  logic [btb_tag_width_p-1:0] upd_tag;
  logic                       empty, full, deq, acc, enq, coal_hit;
  logic [ptr_w-1:0]           wr_sel;
  logic                       unused_pc_bits;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign upd_idx        = upd_pc_i[2 +: btb_idx_width_p];
  assign upd_tag        = upd_pc_i[2 + btb_idx_width_p +: btb_tag_width_p];
  assign unused_pc_bits = ^upd_pc_i;

  assign empty = (count_q == '0);
  assign full  = (count_q == cnt_w'(fifo_els_p));
  assign deq   = (state_q == e_run) & ~empty;

`ifdef BP_FE_BTB_WRITER_COALESCE_EN
  logic [ptr_w-1:0] last_ptr;
  assign last_ptr = (wr_ptr_q == '0) ? ptr_w'(fifo_els_p - 1) : wr_ptr_q - 1'b1;
  // The newest entry is only safe to overwrite if it is not leaving on this edge.
  assign coal_hit = ~empty & (mem_idx_q[last_ptr] == upd_idx)
                  & ~(deq & (count_q == cnt_w'(1)));
  assign wr_sel   = coal_hit ? last_ptr : wr_ptr_q;
`else
  assign coal_hit = 1'b0;
  assign wr_sel   = wr_ptr_q;
`endif

  assign upd_ready_o = (~full | coal_hit) & ~flush_i & ~reset_i;
  assign acc         = upd_v_i & upd_ready_o;
  assign enq         = acc & ~coal_hit;

  always_comb begin
    mem_clr_d = mem_clr_q;
    mem_jmp_d = mem_jmp_q;
    mem_tag_d = mem_tag_q;
    mem_idx_d = mem_idx_q;
    mem_tgt_d = mem_tgt_q;
    rd_ptr_d  = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d  = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (acc) begin
      mem_clr_d[wr_sel] = upd_clr_i;
      mem_jmp_d[wr_sel] = upd_jmp_i;
      mem_tag_d[wr_sel] = upd_tag;
      mem_idx_d[wr_sel] = upd_idx;
      mem_tgt_d[wr_sel] = upd_tgt_i;
    end
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
  end

  // The wait phase gives the BTB one full pass over its index space to clear itself.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      e_reset: begin
        state_d    = e_wait;
        wait_cnt_d = '0;
      end
      e_wait: begin
        if (wait_cnt_q == wait_last) state_d = e_run;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      e_run:   state_d = e_run;
      default: state_d = e_reset;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_reset;
      wait_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      mem_clr_q  <= '{default: '0};
      mem_jmp_q  <= '{default: '0};
      mem_tag_q  <= '{default: '0};
      mem_idx_q  <= '{default: '0};
      mem_tgt_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_clr_q  <= mem_clr_d;
      mem_jmp_q  <= mem_jmp_d;
      mem_tag_q  <= mem_tag_d;
      mem_idx_q  <= mem_idx_d;
      mem_tgt_q  <= mem_tgt_d;
    end
  end

  assign w_v_o    = deq & ~reset_i;
  assign w_clr_o  = reset_i ? 1'b0 : mem_clr_q[rd_ptr_q];
  assign w_jmp_o  = reset_i ? 1'b0 : mem_jmp_q[rd_ptr_q];
  assign w_tag_o  = reset_i ? '0 : mem_tag_q[rd_ptr_q];
  assign w_idx_o  = reset_i ? '0 : mem_idx_q[rd_ptr_q];
  assign br_tgt_o = reset_i ? '0 : mem_tgt_q[rd_ptr_q];

endmodule

// File: tb/tb_bp_fe_btb_writer.sv
// Directed bench for bp_fe_btb_writer; the coalescing scenario follows BP_FE_BTB_WRITER_COALESCE_EN.
module tb_bp_fe_btb_writer;

  localparam int VA  = 39;
  localparam int TAG = 10;
  localparam int IDX = 6;
  localparam int ELS = 4;

  logic           clk;
  logic           reset;
  logic           upd_v, upd_clr, upd_jmp, flush;
  logic [VA-1:0]  upd_pc, upd_tgt;
  logic           upd_ready;
  logic           w_v, w_clr, w_jmp;
  logic [TAG-1:0] w_tag;
  logic [IDX-1:0] w_idx;
  logic [VA-1:0]  br_tgt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bp_fe_btb_writer #(
    .vaddr_width_p  (VA),
    .btb_tag_width_p(TAG),
    .btb_idx_width_p(IDX),
    .fifo_els_p     (ELS)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .upd_v_i    (upd_v),
    .upd_ready_o(upd_ready),
    .upd_clr_i  (upd_clr),
    .upd_jmp_i  (upd_jmp),
    .upd_pc_i   (upd_pc),
    .upd_tgt_i  (upd_tgt),
    .flush_i    (flush),
    .w_v_o      (w_v),
    .w_clr_o    (w_clr),
    .w_jmp_o    (w_jmp),
    .w_tag_o    (w_tag),
    .w_idx_o    (w_idx),
    .br_tgt_o   (br_tgt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic           v;
    logic           clr;
    logic           jmp;
    logic [VA-1:0]  pc;
    logic [VA-1:0]  tgt;
    logic           flush;
    logic           exp_ready;
    logic           exp_wv;
    logic           exp_clr;
    logic           exp_jmp;
    logic [IDX-1:0] exp_idx;
    logic [TAG-1:0] exp_tag;
    logic [VA-1:0]  exp_tgt;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic clr, input logic jmp,
                               input logic [VA-1:0] pc, input logic [VA-1:0] tgt,
                               input logic fl);
    upd_v   = v;
    upd_clr = clr;
    upd_jmp = jmp;
    upd_pc  = pc;
    upd_tgt = tgt;
    flush   = fl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Holds reset for two edges with an update offered, then releases it just after an edge (cycle 0).
  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, VA'(39'h1040), VA'(39'h2000), 1'b0);
    checkOutput("rst_ready", upd_ready, 0);
    checkOutput("rst_wv", w_v, 0);
    checkOutput("rst_tag", w_tag, 0);
    checkOutput("rst_idx", w_idx, 0);
    checkOutput("rst_tgt", br_tgt, 0);
    repeat (2) @(posedge clk);
    #1;
    idle();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic waitWrite(input int budget, output int at, output bit got);
    got = 1'b0;
    at  = -1;
    for (int i = 0; i < budget; i++) begin
      if (w_v === 1'b1) begin
        got = 1'b1;
        at  = cyc;
        return;
      end
      tick();
    end
  endtask

  task automatic checkWrite(input string name, input logic clr, input logic jmp,
                            input logic [IDX-1:0] idx, input logic [TAG-1:0] tag,
                            input logic [VA-1:0] tgt);
    checkOutput({name, "_wv"}, w_v, 1);
    checkOutput({name, "_clr"}, w_clr, clr);
    checkOutput({name, "_idx"}, w_idx, idx);
    checkOutput({name, "_tag"}, w_tag, tag);
    if (!clr) begin
      checkOutput({name, "_jmp"}, w_jmp, jmp);
      checkOutput({name, "_tgt"}, br_tgt, tgt);
    end
  endtask

  initial begin
    int  at;
    bit  got;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 39'h1040, 39'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 10'h000, 39'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 39'h2084, 39'h4444, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h10, 10'h010, 39'h2000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 39'h1040, 39'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h21, 10'h020, 39'h4444};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 39'h0,    39'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h10, 10'h010, 39'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 39'h0,    39'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 10'h000, 39'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 39'h3000, 39'h5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 10'h000, 39'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 39'h0,    39'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 10'h000, 39'h0};

    reset = 1'b1;
    idle();

    // First write after reset lands at cycle 66.
    doReset();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, VA'(39'h1040), VA'(39'h2000), 1'b0);
    checkOutput("first_ready", upd_ready, 1);
    tick();
    idle();
    waitWrite(200, at, got);
    checkOutput("first_write_cycle", at, 66);
    checkWrite("first", 1'b0, 1'b0, 6'h10, 10'h010, VA'(39'h2000));
    tick();
    checkOutput("first_drained", w_v, 0);

    // Fill during the wait phase, then drain four writes in order.
    doReset();
    tick();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, VA'(k * 4), VA'(k * 256), 1'b0);
      checkOutput($sformatf("fill_ready_%0d", k), upd_ready, (k <= ELS) ? 1 : 0);
      tick();
    end
    idle();
    waitWrite(200, at, got);
    checkOutput("fill_write_cycle", at, 66);
    for (int k = 1; k <= 4; k++) begin
      checkWrite($sformatf("drain_%0d", k), 1'b0, 1'b0, IDX'(k), '0, VA'(k * 256));
      tick();
    end
    checkOutput("drain_done", w_v, 0);

    // Back-to-back traffic in e_run from the vector table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].v, vecs[i].clr, vecs[i].jmp, vecs[i].pc, vecs[i].tgt, vecs[i].flush);
      checkOutput($sformatf("vec%0d_ready", i), upd_ready, vecs[i].exp_ready);
      if (vecs[i].exp_wv)
        checkWrite($sformatf("vec%0d", i), vecs[i].exp_clr, vecs[i].exp_jmp,
                   vecs[i].exp_idx, vecs[i].exp_tag, vecs[i].exp_tgt);
      else
        checkOutput($sformatf("vec%0d_wv", i), w_v, 0);
      tick();
    end

    // Reset in the middle of a stream must drop w_v at once and discard the queue.
    applyStimulus(1'b1, 1'b0, 1'b0, VA'(39'h44), VA'(39'h1), 1'b0);
    tick();
    checkOutput("stream_wv", w_v, 1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_wv", w_v, 0);
    checkOutput("async_ready", upd_ready, 0);
    idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, VA'(39'h1040), VA'(39'h2000), 1'b0);
    tick();
    idle();
    waitWrite(200, at, got);
    checkOutput("rewait_write_cycle", at, 66);
    checkWrite("rewait", 1'b0, 1'b0, 6'h10, 10'h010, VA'(39'h2000));
    tick();
    checkOutput("rewait_drained", w_v, 0);

    // Two updates to the same index while the head is held back.
    doReset();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, VA'(39'h1040), VA'(39'h2000), 1'b0);
    checkOutput("coal_ready_a", upd_ready, 1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, VA'(39'h1040), VA'(39'h3000), 1'b0);
    checkOutput("coal_ready_b", upd_ready, 1);
    tick();
    idle();
    waitWrite(200, at, got);
    checkOutput("coal_write_cycle", at, 66);
`ifdef BP_FE_BTB_WRITER_COALESCE_EN
    checkWrite("coal_merged", 1'b0, 1'b0, 6'h10, 10'h010, VA'(39'h3000));
    tick();
`else
    checkWrite("coal_first", 1'b0, 1'b0, 6'h10, 10'h010, VA'(39'h2000));
    tick();
    checkWrite("coal_second", 1'b0, 1'b0, 6'h10, 10'h010, VA'(39'h3000));
    tick();
`endif
    checkOutput("coal_drained", w_v, 0);

    // Flush before e_run leaves nothing to write.
    doReset();
    tick();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, VA'(k * 4), VA'(k * 16), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("flush_ready_low", upd_ready, 0);
    tick();
    idle();
    checkOutput("flush_ready_next", upd_ready, 1);
    waitWrite(100, at, got);
    checkOutput("flush_no_write", got, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
